// File: rtl/synth_pkg.sv
// Shared constants and types for the synth voice path: voice count, note and
// age widths, the allocator FSM states and the note event type encoding.
package synth_pkg;

  localparam int unsigned NUM_VOICES = 16;
  localparam int unsigned NOTE_W     = 7;
  localparam int unsigned AGE_W      = 8;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StCommit
  } alloc_state_e;

  localparam logic NOTE_OFF = 1'b0;
  localparam logic NOTE_ON  = 1'b1;

endpackage

// File: rtl/voice_slot.sv
// One voice slot: holds the note number, gate and a saturating age counter.
// Optional macro SUSTAIN_PEDAL_EN adds a held flag for sustain-pedal release.
module voice_slot #(
  parameter int unsigned NOTE_W = synth_pkg::NOTE_W,
  parameter int unsigned AGE_W  = synth_pkg::AGE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              retrigger,
  input  logic              note_release,
`ifdef SUSTAIN_PEDAL_EN
  input  logic              hold,
  input  logic              held_release,
`endif
  input  logic              age_inc,
  input  logic [NOTE_W-1:0] load_note,
  output logic [NOTE_W-1:0] note,
  output logic              gate,
  output logic [AGE_W-1:0]  age
);

  logic [NOTE_W-1:0] note_q, note_d;
  logic              gate_q, gate_d;
  logic [AGE_W-1:0]  age_q, age_d;
`ifdef SUSTAIN_PEDAL_EN
  logic              held_q, held_d;
`endif

  // Next-state: strobes are mutually exclusive by construction in the allocator.
  always_comb begin
    note_d = note_q;
    gate_d = gate_q;
    age_d  = age_q;
`ifdef SUSTAIN_PEDAL_EN
    held_d = held_q;
`endif
    if (load) begin
      note_d = load_note;
      gate_d = 1'b1;
      age_d  = '0;
`ifdef SUSTAIN_PEDAL_EN
      held_d = 1'b0;
`endif
    end else if (retrigger) begin
      gate_d = 1'b1;
      age_d  = '0;
`ifdef SUSTAIN_PEDAL_EN
      held_d = 1'b0;
`endif
    end else if (note_release) begin
      // Note value is kept so the release tail plays at the right pitch.
      gate_d = 1'b0;
`ifdef SUSTAIN_PEDAL_EN
      held_d = 1'b0;
`endif
    end else if (age_inc) begin
      if (gate_q && (age_q != {AGE_W{1'b1}})) begin
        age_d = age_q + AGE_W'(1);
      end
`ifdef SUSTAIN_PEDAL_EN
    end else if (hold) begin
      held_d = 1'b1;
    end else if (held_release && held_q) begin
      gate_d = 1'b0;
      held_d = 1'b0;
`endif
    end
  end

  // Slot state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      note_q <= '0;
      gate_q <= 1'b0;
      age_q  <= '0;
`ifdef SUSTAIN_PEDAL_EN
      held_q <= 1'b0;
`endif
    end else begin
      note_q <= note_d;
      gate_q <= gate_d;
      age_q  <= age_d;
`ifdef SUSTAIN_PEDAL_EN
      held_q <= held_d;
`endif
    end
  end

  assign note = note_q;
  assign gate = gate_q;
  assign age  = age_q;

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: accepts note-on/off events over valid/ready and
// maps them onto NUM_VOICES slots via a serial scan (one slot per cycle).
// Optional macro SUSTAIN_PEDAL_EN adds the sustain input and held-note release.
module voice_allocator #(
  parameter int unsigned NUM_VOICES = synth_pkg::NUM_VOICES,
  parameter int unsigned NOTE_W     = synth_pkg::NOTE_W,
  parameter int unsigned AGE_W      = synth_pkg::AGE_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [NOTE_W-1:0]            ev_note,
`ifdef SUSTAIN_PEDAL_EN
  input  logic                         sustain,
`endif
  output logic [NUM_VOICES*NOTE_W-1:0] voice_notes,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic                         steal,
  output logic                         busy
);

  import synth_pkg::*;

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  alloc_state_e      state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ev_on_q, ev_on_d;
  logic [NOTE_W-1:0] ev_note_q, ev_note_d;
  logic              match_found_q, match_found_d;
  logic [IDX_W-1:0]  match_idx_q, match_idx_d;
  logic              free_found_q, free_found_d;
  logic [IDX_W-1:0]  free_idx_q, free_idx_d;
  logic              old_found_q, old_found_d;
  logic [IDX_W-1:0]  old_idx_q, old_idx_d;
  logic [AGE_W-1:0]  old_age_q, old_age_d;
  logic              steal_q, steal_d;

  logic [NOTE_W-1:0]     slot_note [NUM_VOICES];
  logic [AGE_W-1:0]      slot_age  [NUM_VOICES];
  logic [NUM_VOICES-1:0] slot_gate;
  logic [NUM_VOICES-1:0] load, retrig, rel, age_inc;
  logic                  service;
  logic                  accept;

`ifdef SUSTAIN_PEDAL_EN
  logic                  sustain_q;
  logic                  pending_q, pending_d;
  logic [NUM_VOICES-1:0] hold_set;

  // Held-note release takes one IDLE cycle and blocks event acceptance.
  assign service = (state_q == StIdle) && pending_q;

  // Latch a sustain falling edge until it can be serviced.
  always_comb begin
    pending_d = pending_q;
    if (service) pending_d = 1'b0;
    if (sustain_q && !sustain) pending_d = 1'b1;
  end

  // Sustain edge detector and pending flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sustain_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      sustain_q <= sustain;
      pending_q <= pending_d;
    end
  end
`else
  assign service = 1'b0;
`endif

  assign ev_ready = (state_q == StIdle) && !service && !reset;
  assign accept   = ev_valid && ev_ready;
  assign busy     = (state_q != StIdle);
  assign steal    = steal_q;

  // FSM next-state, scan trackers and commit strobes.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ev_on_d       = ev_on_q;
    ev_note_d     = ev_note_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    steal_d       = 1'b0;
    load          = '0;
    retrig        = '0;
    rel           = '0;
    age_inc       = '0;
`ifdef SUSTAIN_PEDAL_EN
    hold_set      = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          ev_on_d       = ev_on;
          ev_note_d     = ev_note;
          match_found_d = 1'b0;
          free_found_d  = 1'b0;
          old_found_d   = 1'b0;
          idx_d         = '0;
          state_d       = StScan;
        end
      end
      StScan: begin
        if (slot_gate[idx_q]) begin
          if (!match_found_q && (slot_note[idx_q] == ev_note_q)) begin
            match_found_d = 1'b1;
            match_idx_d   = idx_q;
          end
          // Strict compare keeps the lowest index on an age tie.
          if (!old_found_q || (slot_age[idx_q] > old_age_q)) begin
            old_found_d = 1'b1;
            old_idx_d   = idx_q;
            old_age_d   = slot_age[idx_q];
          end
        end else if (!free_found_q) begin
          free_found_d = 1'b1;
          free_idx_d   = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = StCommit;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      StCommit: begin
        state_d = StIdle;
        unique case (ev_on_q)
          NOTE_ON: begin
            if (match_found_q) begin
              retrig[match_idx_q] = 1'b1;
            end else if (free_found_q) begin
              load[free_idx_q] = 1'b1;
            end else begin
              // No free slot means every slot is gated, so old_idx is valid.
              load[old_idx_q] = 1'b1;
              steal_d         = 1'b1;
            end
            age_inc = slot_gate & ~(load | retrig);
          end
          NOTE_OFF: begin
            if (match_found_q) begin
`ifdef SUSTAIN_PEDAL_EN
              if (sustain) hold_set[match_idx_q] = 1'b1;
              else         rel[match_idx_q]      = 1'b1;
`else
              rel[match_idx_q] = 1'b1;
`endif
            end
          end
        endcase
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and tracker registers; reset discards any event in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      ev_on_q       <= 1'b0;
      ev_note_q     <= '0;
      match_found_q <= 1'b0;
      match_idx_q   <= '0;
      free_found_q  <= 1'b0;
      free_idx_q    <= '0;
      old_found_q   <= 1'b0;
      old_idx_q     <= '0;
      old_age_q     <= '0;
      steal_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ev_on_q       <= ev_on_d;
      ev_note_q     <= ev_note_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      steal_q       <= steal_d;
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    voice_slot #(
      .NOTE_W (NOTE_W),
      .AGE_W  (AGE_W)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .load         (load[i]),
      .retrigger    (retrig[i]),
      .note_release (rel[i]),
`ifdef SUSTAIN_PEDAL_EN
      .hold         (hold_set[i]),
      .held_release (service),
`endif
      .age_inc      (age_inc[i]),
      .load_note    (ev_note_q),
      .note         (slot_note[i]),
      .gate         (slot_gate[i]),
      .age          (slot_age[i])
    );
    assign voice_notes[i*NOTE_W +: NOTE_W] = slot_note[i];
  end

  assign voice_gate = slot_gate;

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed vector table, hand-written
// corner sequences and random events against a slot-list reference model.
module tb_voice_allocator;

  localparam int NV = 16;
  localparam int NW = 7;
  localparam int AGE_MAX = 255;

  logic              clk = 1'b0;
  logic              reset;
  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [NW-1:0]     ev_note;
  logic [NV*NW-1:0]  voice_notes;
  logic [NV-1:0]     voice_gate;
  logic              steal;
  logic              busy;
`ifdef SUSTAIN_PEDAL_EN
  logic              sustain;
`endif

  always #5 clk = ~clk;

  voice_allocator dut (
    .clk         (clk),
    .reset       (reset),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_on       (ev_on),
    .ev_note     (ev_note),
`ifdef SUSTAIN_PEDAL_EN
    .sustain     (sustain),
`endif
    .voice_notes (voice_notes),
    .voice_gate  (voice_gate),
    .steal       (steal),
    .busy        (busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a plain list of slots.
  int m_note [NV];
  bit m_gate [NV];
  int m_age  [NV];

  typedef struct {
    bit          on;
    bit [NW-1:0] note;
    bit [NV-1:0] gate;
    int          slot;
    bit [NW-1:0] slot_note;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NV; i++) begin
      m_note[i] = 0;
      m_gate[i] = 1'b0;
      m_age[i]  = 0;
    end
  endfunction

  function automatic void model_event(input bit on, input int note, output bit stl);
    int match = -1;
    int free = -1;
    int old = -1;
    int tgt;
    stl = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (m_gate[i] && m_note[i] == note && match < 0) match = i;
      if (!m_gate[i] && free < 0) free = i;
      if (m_gate[i] && (old < 0 || m_age[i] > m_age[old])) old = i;
    end
    if (on) begin
      if (match >= 0)     tgt = match;
      else if (free >= 0) tgt = free;
      else begin
        tgt = old;
        stl = 1'b1;
      end
      for (int i = 0; i < NV; i++)
        if (i != tgt && m_gate[i]) m_age[i] = (m_age[i] >= AGE_MAX) ? AGE_MAX : m_age[i] + 1;
      m_note[tgt] = note;
      m_gate[tgt] = 1'b1;
      m_age[tgt]  = 0;
    end else if (match >= 0) begin
      m_gate[match] = 1'b0;
    end
  endfunction

  function automatic logic [NV*NW-1:0] exp_notes();
    logic [NV*NW-1:0] v = '0;
    for (int i = 0; i < NV; i++) v[i*NW +: NW] = NW'(m_note[i]);
    return v;
  endfunction

  function automatic logic [NV-1:0] exp_gates();
    logic [NV-1:0] v = '0;
    for (int i = 0; i < NV; i++) v[i] = m_gate[i];
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ev_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_in_reset", ev_ready, 1'b0);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    chk("rst_ready", ev_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_gate", voice_gate, '0);
    chk("rst_notes", voice_notes, '0);
    chk("rst_steal", steal, 1'b0);
  endtask

  // Present one event and return just after the accepting clock edge.
  task automatic handshake(input bit on, input bit [NW-1:0] note, output bit ok);
    int n = 0;
    @(negedge clk);
    ev_valid = 1'b1;
    ev_on = on;
    ev_note = note;
    while (!ev_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!ev_ready) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout actual=ready_low required=ready_high");
      ev_valid = 1'b0;
      ok = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      ev_valid = 1'b0;
      ok = 1'b1;
    end
  endtask

  // Full event with latency, state and steal checks against the model.
  task automatic apply(input bit on, input bit [NW-1:0] note);
    bit ok;
    bit stl;
    handshake(on, note, ok);
    if (!ok) return;
    model_event(on, int'(note), stl);
    repeat (17) @(negedge clk);
    chk("commit_busy", busy, 1'b1);
    chk("commit_ready", ev_ready, 1'b0);
    @(negedge clk);
    chk("done_ready", ev_ready, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("gates", voice_gate, exp_gates());
    chk("notes", voice_notes, exp_notes());
    chk("steal_pulse", steal, stl);
    @(negedge clk);
    chk("steal_after", steal, 1'b0);
  endtask

  initial begin
    bit ok;
    int accepts;
    int overlap;
    int n;

    reset = 1'b1;
    ev_valid = 1'b0;
    ev_on = 1'b0;
    ev_note = '0;
`ifdef SUSTAIN_PEDAL_EN
    sustain = 1'b0;
`endif
    model_clear();

    vecs[0] = '{1'b1, 7'd60, 16'h0001, 0, 7'd60};
    vecs[1] = '{1'b1, 7'd64, 16'h0003, 1, 7'd64};
    vecs[2] = '{1'b1, 7'd67, 16'h0007, 2, 7'd67};
    vecs[3] = '{1'b0, 7'd64, 16'h0005, 1, 7'd64};
    vecs[4] = '{1'b1, 7'd60, 16'h0005, 0, 7'd60};
    vecs[5] = '{1'b0, 7'd99, 16'h0005, 2, 7'd67};
    vecs[6] = '{1'b1, 7'd0,  16'h0007, 1, 7'd0};
    vecs[7] = '{1'b0, 7'd0,  16'h0005, 1, 7'd0};
    vecs[8] = '{1'b1, 7'd0,  16'h0007, 1, 7'd0};

    // Directed table.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].on, vecs[i].note);
      chk($sformatf("vec%0d_gate", i), voice_gate, vecs[i].gate);
      chk($sformatf("vec%0d_slot_note", i), voice_notes[vecs[i].slot*NW +: NW],
          vecs[i].slot_note);
    end

    // Fill all voices, then steal the oldest.
    do_reset();
    for (int n2 = 40; n2 <= 55; n2++) apply(1'b1, 7'(n2));
    apply(1'b1, 7'd70);
    chk("steal_slot0_note", voice_notes[6:0], 7'd70);
    chk("steal_gates", voice_gate, 16'hFFFF);

    // Age saturation: slot0 must still be oldest after 264 increments.
    do_reset();
    apply(1'b1, 7'd100);
    for (int k = 0; k < 250; k++) apply(1'b1, 7'd101);
    for (int k = 0; k < 14; k++) apply(1'b1, 7'(102 + k));
    apply(1'b1, 7'd120);
    chk("sat_victim_note", voice_notes[6:0], 7'd120);
    chk("sat_slot1_note", voice_notes[13:7], 7'd101);

    // ev_valid held through busy: one accept per idle window, no duplicates.
    do_reset();
    accepts = 0;
    overlap = 0;
    @(negedge clk);
    ev_valid = 1'b1;
    ev_on = 1'b1;
    ev_note = 7'd10;
    for (int k = 0; k < 40; k++) begin
      if (ev_ready) accepts++;
      if (ev_ready && busy) overlap++;
      @(negedge clk);
    end
    ev_valid = 1'b0;
    n = 0;
    while (!ev_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hold_accepts", accepts, 3);
    chk("hold_overlap", overlap, 0);
    chk("hold_gates", voice_gate, 16'h0001);
    chk("hold_note", voice_notes[6:0], 7'd10);

    // Reset in the middle of a scan discards the event.
    do_reset();
    apply(1'b1, 7'd60);
    handshake(1'b1, 7'd64, ok);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_gate", voice_gate, '0);
    chk("midrst_notes", voice_notes, '0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", ev_ready, 1'b0);
    chk("midrst_steal", steal, 1'b0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_lost_gate", voice_gate, '0);
    chk("midrst_ready_after", ev_ready, 1'b1);

`ifdef SUSTAIN_PEDAL_EN
    // Sustain holds a released note until the pedal lifts.
    do_reset();
    @(negedge clk);
    sustain = 1'b1;
    apply(1'b1, 7'd60);
    handshake(1'b0, 7'd60, ok);
    repeat (18) @(negedge clk);
    chk("sus_gate_held", voice_gate, 16'h0001);
    sustain = 1'b0;
    @(negedge clk);
    chk("sus_service_ready", ev_ready, 1'b0);
    @(negedge clk);
    chk("sus_gate_released", voice_gate, 16'h0000);
    chk("sus_note_kept", voice_notes[6:0], 7'd60);
    chk("sus_ready_after", ev_ready, 1'b1);
`endif

    // Random events against the model.
    do_reset();
    for (int k = 0; k < 200; k++) begin
      apply(($urandom_range(0, 3) != 0), 7'($urandom_range(0, 20)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice allocator. Accepts note-on/note-off events over a valid/ready handshake and assigns them to NUM_VOICES voice slots.
- Drives the per-voice note bus that feeds the frequency lookup and oscillator bank. It is the live-input producer end of that bus, replacing the fixed chord generator in playable builds.
- Per-voice gate outputs drive downstream envelopes.

Parameters:
- NUM_VOICES, 16, number of voice slots; must equal the oscillator count.
- NOTE_W, 7, note number width (MIDI 0-127).
- AGE_W, 8, width of the per-slot saturating age counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ev_valid  in  1  event present.
- ev_ready  out  1  allocator can accept an event this cycle.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  NOTE_W  note number of the event.
- voice_notes  out  NUM_VOICES*NOTE_W  packed slot notes; slot i occupies bits [i*NOTE_W +: NOTE_W].
- voice_gate  out  NUM_VOICES  per-slot gate, 1 = key held.
- steal  out  1  one-cycle pulse when a note-on evicted an active voice.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous, any state):
  - voice_notes = 0, voice_gate = 0, all ages = 0.
  - steal = 0, busy = 0.
  - ev_ready = 0 while reset is asserted; ev_ready = 1 on the first clock after release (IDLE).
  - An event in flight is discarded.
- FSM: IDLE -> SCAN -> COMMIT -> IDLE.
  - IDLE: ev_ready = 1. On ev_valid & ev_ready (cycle T), latch ev_on/ev_note, clear the scan trackers, go to SCAN.
  - SCAN: one slot per cycle, idx 0..NUM_VOICES-1, cycles T+1..T+NUM_VOICES. Tracks:
    - match = lowest-index slot with gate = 1 and note == ev_note;
    - free = lowest-index slot with gate = 0;
    - oldest = gated slot with the largest age; on a tie, the lowest index wins.
  - COMMIT (T+NUM_VOICES+1): applies the update. Outputs are visible, and ev_ready = 1 again, at T+NUM_VOICES+2 (18 cycles for 16 voices).
- Note-on, in priority order:
  - If match exists, retrigger it: gate stays 1 and age = 0.
  - Else if free exists, load that slot's note and set gate = 1, age = 0.
  - Else steal oldest: load the new note, age = 0, and pulse steal for one cycle in the COMMIT-output cycle.
  - On every note-on commit, all other gated slots increment age, saturating at 2^AGE_W-1. Ungated slots hold their age.
- Note-off:
  - If match exists, gate = 0. The note value is retained so oscillator and envelope release continue at the correct pitch.
  - If no match, no state change and no error.
- Boundaries:
  - ev_valid while busy: ignored (ev_ready = 0). The producer must hold the event.
  - Repeated note-on for an already gated note never consumes a second slot.
  - Note 0 is a legal note. Free/busy status is decided by gate only.

Optional Feature:
- Macro: SUSTAIN_PEDAL_EN.
- Defined:
  - Adds input port sustain (1 bit) and a per-slot held flag.
  - While sustain = 1, a matching note-off sets held = 1 and leaves gate = 1.
  - A note-on that matches or reuses a slot clears held.
  - A sustain falling edge is registered as pending. It is serviced in the first IDLE cycle: all slots with held = 1 get gate = 0 and held = 0.
  - ev_ready = 0 during that service cycle. Ages are unchanged.
  - Reset clears held and pending.
- Undefined: no sustain port and no held flags; note-off always clears the gate.

Decomposition:
- Shared package synth_pkg:
  - NOTE_W, NUM_VOICES, AGE_W;
  - the allocator state enum (IDLE, SCAN, COMMIT);
  - the NOTE_OFF/NOTE_ON event-type constants.
- Sub-module voice_slot, instanced NUM_VOICES times. It holds note, gate, age (and held); takes load, retrigger, release and age_inc strobes; and exposes note, gate and age to the scan mux.

Test Plan:
- Reset then note-on 60 -> at T+18: slot0 note = 60, gate = 1'b1 in bit 0, all other gates 0, steal = 0.
- Note-on 60, 64, 67, then note-off 64 -> gates = 16'h0005; slot1 note still reads 64.
- Note-on 60 twice -> only slot0 gated (16'h0001), slot0 age = 0.
- Note-on 40..55 (16 voices full), then note-on 70 -> slot0 (40, oldest) note = 70, steal pulses exactly one cycle, gates = 16'hFFFF.
- Note-off 99 with no voice playing it -> all outputs unchanged. ev_valid held high during busy -> accepted only when ev_ready = 1, no duplicate allocation.
- SUSTAIN_PEDAL_EN: sustain = 1, note-on 60, note-off 60 -> gate stays 1. Sustain goes to 0 -> gate 0 within 2 cycles of the FSM reaching IDLE. Reset asserted mid-SCAN -> all outputs 0 and the event is lost.
